// File: rtl/fpga_io_pkg.sv
// Shared sizing and idle-level constants for the FPGA pad path (fpga_io, input conditioner, regs).
package fpga_io_pkg;

    localparam int FPGA_IO_WIDTH = 32;
    localparam int FPGA_IO_CNT_W = 8;
    localparam logic [FPGA_IO_WIDTH-1:0] FPGA_IO_IDLE = 32'hFFFF_FFFF;

    typedef logic [FPGA_IO_WIDTH-1:0] fpga_word_t;

endpackage

// File: rtl/fpga_in_debounce_bit.sv
// One pad bit: two-flop synchroniser followed by a stable-time debounce counter.
// commit/new_level describe the level change taking effect on the coming clock edge.
module fpga_in_debounce_bit
    import fpga_io_pkg::*;
#(
    parameter int   CNT_W     = FPGA_IO_CNT_W,
    parameter logic RESET_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic [CNT_W-1:0] db_len,
    output logic             filt,
    output logic             commit,
    output logic             new_level
);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;

    assign mismatch  = (s2 != filt);
    // Gated by rst_n so a reset edge can never be reported as an edge event.
    assign commit    = rst_n && mismatch && (cnt >= db_len);
    assign new_level = s2;

    // NOTE: every register here uses <= so all flops sample pre-edge values, making s1->s2 a true two-stage pipe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= RESET_BIT;
            s2   <= RESET_BIT;
            filt <= RESET_BIT;
            cnt  <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (!mismatch) begin
                cnt <= '0;
            end else if (cnt >= db_len) begin
                filt <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpga_in_conditioner.sv
// Conditions the registered pad word: per-bit sync + debounce, sticky edge status
// and a single maskable, registered interrupt request.
module fpga_in_conditioner
    import fpga_io_pkg::*;
#(
    parameter int               WIDTH     = FPGA_IO_WIDTH,
    parameter int               CNT_W     = FPGA_IO_CNT_W,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(FPGA_IO_IDLE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] fpga_i,
    input  logic [CNT_W-1:0] db_len,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] irq_mask,
    input  logic [WIDTH-1:0] stat_clr,
    output logic [WIDTH-1:0] din_filt,
    output logic [WIDTH-1:0] stat,
    output logic             irq
);

    logic [WIDTH-1:0] commit;
    logic [WIDTH-1:0] new_level;
    logic [WIDTH-1:0] set;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fpga_in_debounce_bit #(
            .CNT_W     (CNT_W),
            .RESET_BIT (RESET_VAL[i])
        ) u_bit (
            .clk       (clk),
            .rst_n     (rst_n),
            .din       (fpga_i[i]),
            .db_len    (db_len),
            .filt      (din_filt[i]),
            .commit    (commit[i]),
            .new_level (new_level[i])
        );
    end

    assign set = commit & ((new_level & rise_en) | (~new_level & fall_en));

    // Set is OR-ed in after the clear, so a new edge wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat <= '0;
            irq  <= 1'b0;
        end else begin
            stat <= (stat & ~stat_clr) | set;
            irq  <= |(stat & irq_mask);
        end
    end

endmodule

// File: tb/tb_fpga_in_conditioner.sv
// Scoreboard bench for fpga_in_conditioner: a history-based reference model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_fpga_in_conditioner;

    localparam int          W  = 32;
    localparam int          CW = 8;
    localparam logic [31:0] RV = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  fpga_i;
    logic [CW-1:0] db_len;
    logic [W-1:0]  rise_en;
    logic [W-1:0]  fall_en;
    logic [W-1:0]  irq_mask;
    logic [W-1:0]  stat_clr;
    logic [W-1:0]  din_filt;
    logic [W-1:0]  stat;
    logic          irq;

    always #5 clk = ~clk;

    fpga_in_conditioner dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fpga_i   (fpga_i),
        .db_len   (db_len),
        .rise_en  (rise_en),
        .fall_en  (fall_en),
        .irq_mask (irq_mask),
        .stat_clr (stat_clr),
        .din_filt (din_filt),
        .stat     (stat),
        .irq      (irq)
    );

    typedef struct packed {
        logic [W-1:0] filt;
        logic [W-1:0] stat;
        logic         irq;
    } exp_t;

    typedef struct {
        logic [W-1:0] s2;
        bit           rst;
    } hist_t;

    exp_t  exp_q[$];
    hist_t hist[$];

    logic [W-1:0] m_s1, m_s2, m_filt, m_stat;
    logic         m_irq;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // A bit commits once the synchronised input has disagreed with the filtered level
    // on db_len+1 consecutive non-reset edges, counted by scanning back through history.
    function automatic void model_edge();
        logic [W-1:0] nf;
        logic [W-1:0] set;
        if (!rst_n) begin
            m_s1 = RV; m_s2 = RV; m_filt = RV; m_stat = '0; m_irq = 1'b0;
            hist.push_back('{s2: RV, rst: 1'b1});
        end else begin
            hist.push_back('{s2: m_s2, rst: 1'b0});
            nf  = m_filt;
            set = '0;
            for (int i = 0; i < W; i++) begin
                int run = 0;
                for (int k = hist.size() - 1; k >= 0 && run <= int'(db_len); k--) begin
                    if (hist[k].rst || hist[k].s2[i] == m_filt[i]) break;
                    run++;
                end
                if (run >= int'(db_len) + 1) begin
                    nf[i]  = m_s2[i];
                    set[i] = m_s2[i] ? rise_en[i] : fall_en[i];
                end
            end
            m_irq  = |(m_stat & irq_mask);
            m_stat = (m_stat & ~stat_clr) | set;
            m_filt = nf;
            m_s2   = m_s1;
            m_s1   = fpga_i;
        end
        while (hist.size() > 260) void'(hist.pop_front());
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        exp_q.push_back('{filt: m_filt, stat: m_stat, irq: m_irq});
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_din_filt", din_filt, e.filt);
            check("sb_stat", stat, e.stat);
            check("sb_irq", {31'b0, irq}, {31'b0, e.irq});
        end
    end

    initial begin
        int t_filt, t_stat, t_irq;
        bit fell;
        rst_n = 1'b0; fpga_i = '0; db_len = '0;
        rise_en = '0; fall_en = '0; irq_mask = '0; stat_clr = '0;

        // 1: reset with pads low, then release and let everything debounce low
        rise_en = RV; fall_en = RV; irq_mask = RV; db_len = 8'd3;
        steps(2);
        check("t1_rst_filt", din_filt, RV);
        check("t1_rst_stat", stat, 32'h0);
        check("t1_rst_irq", {31'b0, irq}, 32'h0);
        rst_n = 1'b1;
        steps(3);
        check("t1_no_early_stat", stat, 32'h0);
        steps(8);
        check("t1_all_fell", din_filt, 32'h0);
        rise_en = '0; fall_en = '0; irq_mask = '0;
        fpga_i = RV;
        steps(10);
        stat_clr = RV; step(); stat_clr = '0;
        steps(2);

        // 2: falling edge latency on bit 0 with db_len=4
        db_len = 8'd4; fall_en = 32'h1; irq_mask = 32'h1;
        fpga_i[0] = 1'b0;
        t_filt = 0; t_stat = 0; t_irq = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (t_filt == 0 && din_filt[0] == 1'b0) t_filt = n;
            if (t_stat == 0 && stat[0] == 1'b1) t_stat = n;
            if (t_irq == 0 && irq == 1'b1) t_irq = n;
        end
        check("t2_filt_lat", t_filt, 7);
        check("t2_stat_lat", t_stat, 7);
        check("t2_irq_lat", t_irq, 8);

        // 3: 4-cycle glitch rejected, 5-cycle pulse accepted on bit 3
        fall_en[3] = 1'b1;
        fpga_i[3] = 1'b0; steps(4); fpga_i[3] = 1'b1;
        steps(10);
        check("t3_glitch_filt", {31'b0, din_filt[3]}, 32'h1);
        check("t3_glitch_stat", {31'b0, stat[3]}, 32'h0);
        fell = 1'b0;
        fpga_i[3] = 1'b0;
        for (int n = 0; n < 5; n++) begin step(); if (!din_filt[3]) fell = 1'b1; end
        fpga_i[3] = 1'b1;
        for (int n = 0; n < 4; n++) begin step(); if (!din_filt[3]) fell = 1'b1; end
        check("t3_pulse_fell", {31'b0, fell}, 32'h1);
        steps(6);

        // 4: no filtering, bit 31 toggling every 2 clk
        db_len = 8'd0; rise_en[31] = 1'b1; fall_en[31] = 1'b1;
        stat_clr[31] = 1'b1; step(); stat_clr = '0;
        for (int n = 0; n < 8; n++) begin
            fpga_i[31] = ~fpga_i[31];
            steps(2);
        end
        check("t4_stat31", {31'b0, stat[31]}, 32'h1);
        steps(4);

        // 5: clear colliding with a new commit on bit 0, then a plain clear
        rise_en[0] = 1'b1; irq_mask = 32'h1;
        fpga_i[0] = 1'b1;
        steps(2);
        stat_clr = 32'h1; step(); stat_clr = '0;
        check("t5_set_wins", {31'b0, stat[0]}, 32'h1);
        check("t5_filt_rose", {31'b0, din_filt[0]}, 32'h1);
        stat_clr = 32'h1; step(); stat_clr = '0;
        check("t5_cleared", {31'b0, stat[0]}, 32'h0);
        step();
        check("t5_irq_low", {31'b0, irq}, 32'h0);

        // 6: reset mid-count on bit 7 with a long stable time
        db_len = 8'd200; fall_en[7] = 1'b1;
        stat_clr = RV; step(); stat_clr = '0;
        fpga_i[7] = 1'b0;
        steps(102);
        rst_n = 1'b0; fpga_i = RV; step(); rst_n = 1'b1;
        check("t6_rst_filt7", {31'b0, din_filt[7]}, 32'h1);
        check("t6_rst_stat", stat, 32'h0);
        fpga_i[7] = 1'b0;
        steps(120);
        check("t6_cnt_restarted", {31'b0, din_filt[7]}, 32'h1);
        fpga_i = RV;
        steps(5);

        // Random phase: slowly moving pads, occasional config changes, clears and resets
        db_len = 8'd2;
        for (int n = 0; n < 2500; n++) begin
            fpga_i = fpga_i ^ ($urandom & $urandom & $urandom);
            if ($urandom_range(0, 49) == 0) db_len = CW'($urandom_range(0, 6));
            if ($urandom_range(0, 39) == 0) rise_en = $urandom;
            if ($urandom_range(0, 39) == 0) fall_en = $urandom;
            if ($urandom_range(0, 39) == 0) irq_mask = $urandom & $urandom;
            stat_clr = ($urandom_range(0, 7) == 0) ? $urandom : '0;
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n = 1'b1; stat_clr = '0;
        steps(2);
        @(negedge clk); #1;
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
